// File: rtl/maxpool2d_ctrl_if.sv
// maxpool2d_ctrl_if
// Control/handshake bundle between the 2x2 max-pool sequencer and its
// surroundings (upstream pixel stream, line buffer / window datapath,
// downstream result consumer).
//
// Signals:
//   start        frame start request (sampled by the controller in IDLE)
//   in_valid     upstream pixel valid
//   in_ready     controller can accept a pixel
//   lb_valid_in  line-buffer / delay-register shift enable
//   win_load     datapath loads the window registers
//   pool_en      datapath computes max of 4 into the output register
//   out_valid    pooled result valid
//   out_ready    downstream accepts the result
//   busy         controller is not idle
//   frame_done   one-cycle end-of-frame pulse
//   row_idx      row of the next pixel to accept
//   col_idx      column of the next pixel to accept
//
// Modports:
//   slave   the controller side
//   master  the environment that drives start/in_valid/out_ready
interface maxpool2d_ctrl_if #(
  parameter int CW = 7,
  parameter int RW = 7
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          lb_valid_in;
  logic          win_load;
  logic          pool_en;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          frame_done;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;

  modport slave (
    input  start,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output lb_valid_in,
    output win_load,
    output pool_en,
    output out_valid,
    output busy,
    output frame_done,
    output row_idx,
    output col_idx
  );

  modport master (
    output start,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  lb_valid_in,
    input  win_load,
    input  pool_en,
    input  out_valid,
    input  busy,
    input  frame_done,
    input  row_idx,
    input  col_idx
  );
endinterface

// File: rtl/maxpool2d_ctrl.sv
// maxpool2d_ctrl
// Sequencer for the 2x2 stride-2 max-pool stage. Accepts a raster-order
// pixel stream, drives the shift enable of the external row line buffer
// (depth IMG_WIDTH, registered data_out) and window registers, pulses
// pool_en when a full 2x2 window is present, and owns the one-entry
// output handshake, back-pressuring upstream while a result is held.
//
// Ports:
//   Clk   rising-edge clock
//   Rst   asynchronous active-low reset
//   bus   maxpool2d_ctrl_if.slave (stream, datapath strobes, status)
//
// State table:
//   IDLE  | waiting for start; no pixels accepted
//   RUN   | accepting pixels, counters advance per accept
//   DRAIN | input closed; wait for last pool and result hand-off
//   DONE  | one-cycle frame_done pulse, back to IDLE
module maxpool2d_ctrl #(
  parameter int IMG_WIDTH  = 98,
  parameter int IMG_HEIGHT = 98,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic             Clk,
  input  logic             Rst,
  maxpool2d_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  // One extra bit so an even dimension equal to 2**CW still fits.
  localparam logic [CW:0]   COL_LIM  = (CW+1)'(IMG_WIDTH - (IMG_WIDTH % 2));
  localparam logic [RW:0]   ROW_LIM  = (RW+1)'(IMG_HEIGHT - (IMG_HEIGHT % 2));

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] d_col;
  logic [RW-1:0] d_row;
  logic          d_valid;
  logic          out_valid_q;
  logic          in_ready;
  logic          accept;
  logic          last_col;
  logic          last_pix;
  logic          pool_hit;
  logic          busy_c;
  logic          frame_done_c;

  // Combinational from out_ready so a result consumed this cycle frees
  // the slot for the pixel accepted this cycle.
  assign in_ready = (state == RUN) & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign last_col = (col_q == COL_LAST);
  assign last_pix = last_col & (row_q == ROW_LAST);

  // The tag names the pixel shifted in last cycle; a window closes on its
  // bottom-right pixel (odd row, odd column). A trailing odd row/column is
  // still shifted but never pooled.
  assign pool_hit = d_valid & d_row[0] & d_col[0]
                  & ({1'b0, d_col} < COL_LIM)
                  & ({1'b0, d_row} < ROW_LIM);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy_c       = 1'b1;
    frame_done_c = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept && last_pix) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once nothing is in flight and the held result (if any)
        // is being taken this cycle.
        if (!pool_hit && (!out_valid_q || bus.out_ready)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        frame_done_c = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Position counters: cleared on start, advanced per accept, held at the
  // last pixel so they never wrap past the frame end.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (state == IDLE && bus.start) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept && !last_pix) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      d_valid <= 1'b0;
      d_col   <= '0;
      d_row   <= '0;
    end else begin
      d_valid <= accept;
      if (accept) begin
        d_col <= col_q;
        d_row <= row_q;
      end
    end
  end

  // A new result has priority over the hand-off; two pool strobes are at
  // least two cycles apart so a held result is never overwritten.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_valid_q <= 1'b0;
    end else if (pool_hit) begin
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.lb_valid_in = accept;
  assign bus.win_load    = d_valid;
  assign bus.pool_en     = pool_hit;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_c;
  assign bus.frame_done  = frame_done_c;
  assign bus.row_idx     = row_q;
  assign bus.col_idx     = col_q;

endmodule

// File: tb/tb_maxpool2d_ctrl.sv
// tb_maxpool2d_ctrl
// Four controller instances (4x4, 5x5, 8x8, 98x98) share one stimulus
// bus; sel routes start/in_valid to one of them and picks its outputs.
// A behavioural line buffer / window / max datapath produces results that
// are compared against a scoreboard filled from the pixel image.
module tb_maxpool2d_ctrl;
  localparam int NI = 4;
  localparam int WS [NI] = '{4, 5, 8, 98};
  localparam int HS [NI] = '{4, 5, 8, 98};
  localparam int MAXN = 98 * 98;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] pix = 8'd0;
  logic [1:0] sel = 2'd0;

  logic [NI-1:0]      o_ir, o_lb, o_wl, o_pe, o_ov, o_busy, o_fd;
  logic [NI-1:0][7:0] o_row, o_col;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    maxpool2d_ctrl_if #(.CW($clog2(WS[g])), .RW($clog2(HS[g]))) bus ();
    assign bus.start     = start & (sel == 2'(g));
    assign bus.in_valid  = in_valid & (sel == 2'(g));
    assign bus.out_ready = out_ready;
    maxpool2d_ctrl #(.IMG_WIDTH(WS[g]), .IMG_HEIGHT(HS[g])) u_dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus)
    );
    assign o_ir[g]   = bus.in_ready;
    assign o_lb[g]   = bus.lb_valid_in;
    assign o_wl[g]   = bus.win_load;
    assign o_pe[g]   = bus.pool_en;
    assign o_ov[g]   = bus.out_valid;
    assign o_busy[g] = bus.busy;
    assign o_fd[g]   = bus.frame_done;
    assign o_row[g]  = 8'(bus.row_idx);
    assign o_col[g]  = 8'(bus.col_idx);
  end

  logic       ir, lb, wl, pe, ov, busy, fd;
  logic [7:0] row, col;
  int         cur_w, cur_h;
  assign ir   = o_ir[sel];
  assign lb   = o_lb[sel];
  assign wl   = o_wl[sel];
  assign pe   = o_pe[sel];
  assign ov   = o_ov[sel];
  assign busy = o_busy[sel];
  assign fd   = o_fd[sel];
  assign row  = o_row[sel];
  assign col  = o_col[sel];
  always_comb begin
    cur_w = WS[sel];
    cur_h = HS[sel];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] max4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    logic [7:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Datapath model: line buffer with registered output, one-pixel delay,
  // left-column window registers, max-of-4 output register.
  logic [7:0] lbuf [0:127];
  logic [7:0] lb_out, d_pix, wt, wb, res;
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lb_out <= 8'd0;
      d_pix  <= 8'd0;
      wt     <= 8'd0;
      wb     <= 8'd0;
      res    <= 8'd0;
    end else begin
      if (lb) begin
        for (int i = 127; i > 0; i--) lbuf[i] <= lbuf[i-1];
        lbuf[0] <= pix;
        lb_out  <= lbuf[cur_w-1];
        d_pix   <= pix;
      end
      if (wl) begin
        wt <= lb_out;
        wb <= d_pix;
      end
      if (pe) res <= max4(wt, wb, lb_out, d_pix);
    end
  end

  logic [7:0] pix_mem [0:MAXN-1];
  logic [7:0] sb [$];
  int         res_cnt = 0;

  // Monitor / scoreboard
  initial begin
    int  mk, r, c;
    bit  exp_wl, exp_pe;
    mk = 0; exp_wl = 0; exp_pe = 0;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        sb.delete();
        mk = 0; res_cnt = 0; exp_wl = 0; exp_pe = 0;
      end else begin
        chk("win_load", wl, exp_wl);
        chk("pool_en", pe, exp_pe);
        if (ov && !out_ready) begin
          chk("stall_in_ready", ir, 0);
          chk("stall_lb_valid", lb, 0);
        end
        if (!busy) begin
          chk("idle_in_ready", ir, 0);
          chk("idle_lb_valid", lb, 0);
        end
        exp_wl = 0;
        exp_pe = 0;
        if (start && !busy) begin
          mk = 0;
          res_cnt = 0;
        end
        if (in_valid && ir) begin
          r = mk / cur_w;
          c = mk % cur_w;
          chk("row_idx", row, r);
          chk("col_idx", col, c);
          exp_wl = 1;
          if (r % 2 == 1 && c % 2 == 1 && c < cur_w - cur_w % 2 && r < cur_h - cur_h % 2) begin
            exp_pe = 1;
            sb.push_back(max4(pix_mem[(r-1)*cur_w + c-1], pix_mem[(r-1)*cur_w + c],
                              pix_mem[r*cur_w + c-1], pix_mem[r*cur_w + c]));
          end
          mk++;
        end
        if (ov && out_ready) begin
          if (sb.size() == 0) chk("spurious_result", 1, 0);
          else chk("result", res, sb.pop_front());
          res_cnt++;
        end
      end
    end
  end

  task automatic run_frame(input logic [1:0] s, input int gap, input int stall,
                           input bit poke, input int abort_at);
    int w, h, n, k, cyc, stall_left, m;
    bit stalled, got;
    sel = s;
    w = WS[s];
    h = HS[s];
    n = w * h;
    for (int i = 0; i < n; i++) pix_mem[i] = (s < 2) ? 8'(i) : 8'($urandom_range(255));
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    k = 0; cyc = 0; stall_left = 0; stalled = 0;
    while (k < n && cyc < 60000) begin
      in_valid = ($urandom_range(99) >= gap);
      pix = pix_mem[k];
      if (stall > 0 && !stalled && ov) begin
        stalled = 1;
        stall_left = stall;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      start = poke && (k == n / 2);
      @(negedge Clk);
      if (in_valid && ir) k++;
      if (abort_at >= 0 && k == abort_at) break;
      @(posedge Clk); #1;
      cyc++;
    end
    if (abort_at >= 0) begin
      #2 Rst = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", ir, 0);
      chk("abort_lb_valid", lb, 0);
      chk("abort_win_load", wl, 0);
      chk("abort_pool_en", pe, 0);
      chk("abort_out_valid", ov, 0);
      chk("abort_frame_done", fd, 0);
      chk("abort_row", row, 0);
      chk("abort_col", col, 0);
      in_valid = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk); #2 Rst = 1'b1;
      return;
    end
    if (k < n) chk("accept_timeout", k, n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = poke;
    m = 0; got = 0;
    while (!got && m < 50) begin
      @(negedge Clk);
      m++;
      if (fd) got = 1;
      else begin
        @(posedge Clk); #1 start = 1'b0;
      end
    end
    chk("frame_done_seen", got, 1);
    if (got) begin
      chk("drain_cycles", m, (w % 2 == 0 && h % 2 == 0) ? 3 : 2);
      chk("out_valid_at_done", ov, 0);
      @(posedge Clk); #1 start = 1'b0;
      @(negedge Clk);
      chk("busy_after_done", busy, 0);
      chk("frame_done_width", fd, 0);
    end
    chk("result_count", res_cnt, (w / 2) * (h / 2));
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_busy", o_busy[g], 0);
      chk("rst_in_ready", o_ir[g], 0);
      chk("rst_out_valid", o_ov[g], 0);
      chk("rst_pool_en", o_pe[g], 0);
      chk("rst_win_load", o_wl[g], 0);
      chk("rst_frame_done", o_fd[g], 0);
      chk("rst_row", o_row[g], 0);
      chk("rst_col", o_col[g], 0);
    end
    @(negedge Clk); #2 Rst = 1'b1;

    sel = 2'd0;
    @(posedge Clk); #1 in_valid = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("idle_valid_in_ready", ir, 0);
      chk("idle_valid_lb", lb, 0);
      chk("idle_valid_row", row, 0);
      chk("idle_valid_col", col, 0);
    end
    @(posedge Clk); #1 in_valid = 1'b0;

    run_frame(2'd0, 0, 0, 1'b0, -1);        // 4x4, back-to-back
    run_frame(2'd0, 0, 5, 1'b0, -1);        // 4x4, 5-cycle output stall
    run_frame(2'd1, 0, 0, 1'b1, -1);        // 5x5, start poked in RUN and DRAIN
    run_frame(2'd2, 0, 0, 1'b0, 8*2 + 3);   // 8x8, reset during row 2
    run_frame(2'd2, 30, 0, 1'b0, -1);       // 8x8 restart
    run_frame(2'd3, 50, 0, 1'b0, -1);       // 98x98, random gaps

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
